rob_retire_unit: RTL and testbench
==================================

Name: rob_retire_unit

Overview:
In-order retire end of the reorder buffer.
- Tracks per-entry completion flags and the head pointer.
- Accepts up to 2 out-of-order completion reports per cycle.
- Retires the contiguous completed prefix from head, up to 4 entries per cycle, in program order.
- Sits between the OoO execution writeback buses and the architectural register commit logic; the ROB allocation side feeds it allocation counts.

Parameters:
- robIndexWidth, 7, ROB index width.
- numRobEntries, 2**robIndexWidth, entry count; must be a power of two.
- regIdWidth, 5, destination register ID width.

Ports:
- clock_i  in  1  single clock.
- reset_i  in  1  asynchronous, active-low reset.
- allocValid_i  in  1  allocate allocCount_i entries at the logical tail this cycle.
- allocCount_i  in  3  allocation count, 1..4; 0 or >4 is illegal.
- allocReady_o  out  1  high when at least 4 entries are free; combinational from occupancy.
- comp1Valid_i, comp2Valid_i  in  1 each  completion report valid.
- comp1Index_i, comp2Index_i  in  robIndexWidth each  ROB index of the completed instruction.
- flush_i  in  1  discard all in-flight entries.
- rdAddr1_o..rdAddr4_o  out  robIndexWidth each  combinational head+0..head+3 (mod numRobEntries), dest-reg array read addresses.
- rdData1_i..rdData4_i  in  regIdWidth each  combinational dest reg ID read back.
- retire1Valid_o..retire4Valid_o  out  1 each  registered; thermometer coded, lane 1 oldest.
- retire1Index_o..retire4Index_o  out  robIndexWidth each  registered index of the retired entry.
- retire1RegId_o..retire4RegId_o  out  regIdWidth each  registered dest reg ID.
- head_o  out  robIndexWidth  oldest in-flight index.
- occupancy_o  out  robIndexWidth+1  in-flight entry count, 0..numRobEntries.
- isEmpty_o, isFull_o  out  1 each  occupancy==0 / occupancy==numRobEntries.
- compErr_o  out  1  sticky: completion reported to a non-in-flight entry.

Behaviour:
- Reset (reset_i low, async): head=0, occupancy=0, all completion flags=0, all retireN outputs=0, compErr_o=0, isEmpty_o=1, isFull_o=0, allocReady_o=1.
- In-flight entries are head..head+occupancy-1 (mod N). The tail is implicit: head+occupancy.
- Allocation (allocValid_i && allocReady_o): clear completion flags at tail+0..tail+allocCount_i-1.
  - allocValid_i while allocReady_o is low is ignored; the allocator must stall.
- Completion: a valid report to an in-flight index sets its flag at the next edge.
  - Both ports may target any index. Same index on both ports is benign.
  - Report to an out-of-flight index: flag unchanged, compErr_o set until reset.
- Retire decision (combinational, current state):
  - k = count of consecutive set flags starting at head.
  - k is limited to 4 and to occupancy.
  - At the edge: retire1..k Valid_o=1, the remaining lanes 0.
  - Lane n captures Index=head+n-1 and RegId=rdDatan_i.
  - Each retired entry's flag is cleared; head += k (wraps mod N).
- Latency: completion sampled at edge E sets the flag at E; the earliest retire output appears after edge E+1. Completion-to-retire-visible is 2 edges, with no same-cycle bypass.
- Occupancy update: occupancy_next = occupancy + (alloc accepted ? allocCount_i : 0) - k.
  - Allocation and retire in the same cycle never collide, because allocation targets free slots only.
- Non-contiguous completion, e.g. head+1 done and head not done: nothing retires until head completes.
- flush_i (highest priority, synchronous):
  - head <= head+occupancy, occupancy <= 0, all flags cleared, all retire valids 0 next cycle.
  - Allocation and completion in the same cycle are dropped; compErr_o is not set by them.
- Full: occupancy==N, isFull_o=1, allocReady_o=0.
- Wrap: indices compare modulo N. An in-flight test uses (index-head) mod N < occupancy.
- Reset mid-operation: immediate asynchronous clear. Outputs show reset values while reset_i is low.

Test Plan:
- Reset, alloc 4, complete idx 0..3 in order 3,1,2,0 over 4 cycles -> no retire until idx 0 completes; then a single cycle with retire1..4Valid=1, indices 0,1,2,3, head=4, occupancy=0.
- Alloc 4, complete idx 1 and 2 only -> no retire for 10 cycles; complete idx 0 -> retire1..3Valid=1 (0,1,2), retire4Valid=0, head=3, occupancy=1.
- Fill to 128 with alloc 4 per cycle -> isFull_o=1 and allocReady_o=0 once occupancy reaches 128 (allocReady_o already low from 125); allocValid held high adds nothing.
- Start head=126 (via prior alloc/retire), alloc 4, complete all -> retire indices 126,127,0,1; head=2.
- Completion to idx 50 while in-flight is 0..7 -> compErr_o=1 and stays 1; flag 50 stays clear.
- Alloc 8 with 3 completed, assert flush_i together with alloc 4 and comp idx 0 -> occupancy=0, head=8, no retire valids; then a 4-entry alloc starts at idx 8.
- Drop reset_i low mid-retire -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/rob_retire_unit.sv
// In-order retire end of the reorder buffer: per-entry completion flags, head pointer,
// two completion ports and up to four in-order retirements per cycle.
module rob_retire_unit #(
    parameter int robIndexWidth = 7,
    parameter int numRobEntries = 2 ** robIndexWidth,
    parameter int regIdWidth    = 5
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     allocValid_i,
    input  logic [2:0]               allocCount_i,
    output logic                     allocReady_o,
    input  logic                     comp1Valid_i,
    input  logic [robIndexWidth-1:0] comp1Index_i,
    input  logic                     comp2Valid_i,
    input  logic [robIndexWidth-1:0] comp2Index_i,
    input  logic                     flush_i,
    output logic [robIndexWidth-1:0] rdAddr1_o,
    output logic [robIndexWidth-1:0] rdAddr2_o,
    output logic [robIndexWidth-1:0] rdAddr3_o,
    output logic [robIndexWidth-1:0] rdAddr4_o,
    input  logic [regIdWidth-1:0]    rdData1_i,
    input  logic [regIdWidth-1:0]    rdData2_i,
    input  logic [regIdWidth-1:0]    rdData3_i,
    input  logic [regIdWidth-1:0]    rdData4_i,
    output logic                     retire1Valid_o,
    output logic                     retire2Valid_o,
    output logic                     retire3Valid_o,
    output logic                     retire4Valid_o,
    output logic [robIndexWidth-1:0] retire1Index_o,
    output logic [robIndexWidth-1:0] retire2Index_o,
    output logic [robIndexWidth-1:0] retire3Index_o,
    output logic [robIndexWidth-1:0] retire4Index_o,
    output logic [regIdWidth-1:0]    retire1RegId_o,
    output logic [regIdWidth-1:0]    retire2RegId_o,
    output logic [regIdWidth-1:0]    retire3RegId_o,
    output logic [regIdWidth-1:0]    retire4RegId_o,
    output logic [robIndexWidth-1:0] head_o,
    output logic [robIndexWidth:0]   occupancy_o,
    output logic                     isEmpty_o,
    output logic                     isFull_o,
    output logic                     compErr_o
);
    localparam int W     = robIndexWidth;
    localparam int N     = numRobEntries;
    localparam int LANES = 4;
    localparam logic [W:0] N_OCC = (W+1)'(N);

    logic [N-1:0]          flags_q, flags_d;
    logic [W-1:0]          head_q, head_d;
    logic [W:0]            occ_q, occ_d;
    logic                  comp_err_q, comp_err_d;
    logic [LANES-1:0]      ret_valid_q, ret_valid_d;
    logic [W-1:0]          ret_index_q [LANES];
    logic [W-1:0]          ret_index_d [LANES];
    logic [regIdWidth-1:0] ret_reg_q [LANES];
    logic [regIdWidth-1:0] ret_reg_d [LANES];

    logic [W-1:0]          lane_addr [LANES];
    logic [regIdWidth-1:0] lane_data [LANES];
    logic [LANES-1:0]      lane_done, lane_ret;
    logic [2:0]            ret_count;
    logic [W-1:0]          tail;
    logic [W-1:0]          comp1_off, comp2_off;
    logic                  comp1_in, comp2_in;
    logic                  alloc_ready, alloc_fire;
    logic [W:0]            alloc_add;

    assign lane_data[0] = rdData1_i;
    assign lane_data[1] = rdData2_i;
    assign lane_data[2] = rdData3_i;
    assign lane_data[3] = rdData4_i;

    // A lane may retire only if it and every older lane are in flight and completed.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_addr[gi] = head_q + W'(gi);
        assign lane_done[gi] = flags_q[lane_addr[gi]] && (occ_q > (W+1)'(gi));
        if (gi == 0) begin : g_first
            assign lane_ret[gi] = lane_done[gi];
        end else begin : g_rest
            assign lane_ret[gi] = lane_ret[gi-1] && lane_done[gi];
        end
    end

    always_comb begin
        ret_count = '0;
        for (int i = 0; i < LANES; i++) begin
            ret_count = ret_count + {2'b00, lane_ret[i]};
        end
    end

    assign tail        = head_q + occ_q[W-1:0];
    assign comp1_off   = comp1Index_i - head_q;
    assign comp2_off   = comp2Index_i - head_q;
    assign comp1_in    = {1'b0, comp1_off} < occ_q;
    assign comp2_in    = {1'b0, comp2_off} < occ_q;
    assign alloc_ready = occ_q <= (N_OCC - (W+1)'(4));
    assign alloc_fire  = allocValid_i && alloc_ready &&
                         (allocCount_i != 3'd0) && (allocCount_i <= 3'd4);
    assign alloc_add   = alloc_fire ? (W+1)'(allocCount_i) : '0;

    always_comb begin
        flags_d     = flags_q;
        head_d      = head_q;
        occ_d       = occ_q;
        comp_err_d  = comp_err_q;
        ret_valid_d = '0;
        for (int i = 0; i < LANES; i++) begin
            ret_index_d[i] = '0;
            ret_reg_d[i]   = '0;
        end
        if (flush_i) begin
            flags_d = '0;
            head_d  = tail;
            occ_d   = '0;
        end else begin
            if (comp1Valid_i) begin
                if (comp1_in) flags_d[comp1Index_i] = 1'b1;
                else          comp_err_d = 1'b1;
            end
            if (comp2Valid_i) begin
                if (comp2_in) flags_d[comp2Index_i] = 1'b1;
                else          comp_err_d = 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                if (lane_ret[i]) begin
                    flags_d[lane_addr[i]] = 1'b0;
                    ret_valid_d[i]        = 1'b1;
                    ret_index_d[i]        = lane_addr[i];
                    ret_reg_d[i]          = lane_data[i];
                end
            end
            // Newly allocated slots lie outside the in-flight window, so they never alias a retiring lane.
            if (alloc_fire) begin
                for (int i = 0; i < LANES; i++) begin
                    if (3'(i) < allocCount_i) flags_d[tail + W'(i)] = 1'b0;
                end
            end
            head_d = head_q + W'(ret_count);
            occ_d  = occ_q + alloc_add - (W+1)'(ret_count);
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            flags_q     <= '0;
            head_q      <= '0;
            occ_q       <= '0;
            comp_err_q  <= 1'b0;
            ret_valid_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                ret_index_q[i] <= '0;
                ret_reg_q[i]   <= '0;
            end
        end else begin
            flags_q     <= flags_d;
            head_q      <= head_d;
            occ_q       <= occ_d;
            comp_err_q  <= comp_err_d;
            ret_valid_q <= ret_valid_d;
            for (int i = 0; i < LANES; i++) begin
                ret_index_q[i] <= ret_index_d[i];
                ret_reg_q[i]   <= ret_reg_d[i];
            end
        end
    end

    assign allocReady_o   = alloc_ready;
    assign rdAddr1_o      = lane_addr[0];
    assign rdAddr2_o      = lane_addr[1];
    assign rdAddr3_o      = lane_addr[2];
    assign rdAddr4_o      = lane_addr[3];
    assign retire1Valid_o = ret_valid_q[0];
    assign retire2Valid_o = ret_valid_q[1];
    assign retire3Valid_o = ret_valid_q[2];
    assign retire4Valid_o = ret_valid_q[3];
    assign retire1Index_o = ret_index_q[0];
    assign retire2Index_o = ret_index_q[1];
    assign retire3Index_o = ret_index_q[2];
    assign retire4Index_o = ret_index_q[3];
    assign retire1RegId_o = ret_reg_q[0];
    assign retire2RegId_o = ret_reg_q[1];
    assign retire3RegId_o = ret_reg_q[2];
    assign retire4RegId_o = ret_reg_q[3];
    assign head_o         = head_q;
    assign occupancy_o    = occ_q;
    assign isEmpty_o      = (occ_q == '0);
    assign isFull_o       = (occ_q == N_OCC);
    assign compErr_o      = comp_err_q;
endmodule

// File: tb/tb_rob_retire_unit.sv
// Randomized and directed bench for rob_retire_unit against a behavioural ROB model.
module tb_rob_retire_unit;
    localparam int N = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic alloc_v = 1'b0;
    logic [2:0] alloc_c = 3'd0;
    logic c1_v = 1'b0, c2_v = 1'b0, flush = 1'b0;
    logic [6:0] c1_i = '0, c2_i = '0;
    logic alloc_rdy, empty, full, err;
    logic [3:0][6:0] rda;
    logic [3:0][4:0] rdd;
    logic [3:0] rv;
    logic [3:0][6:0] ridx;
    logic [3:0][4:0] rreg;
    logic [6:0] head;
    logic [7:0] occ;

    logic [4:0] dest_mem [N];

    int errors = 0;
    int checks = 0;

    bit m_done [N];
    int m_head, m_occ;
    bit m_err;
    bit e_v [4];
    int e_idx [4];
    int e_reg [4];

    always #5 clk = ~clk;

    always_comb begin
        for (int n = 0; n < 4; n++) rdd[n] = dest_mem[rda[n]];
    end

    rob_retire_unit dut (
        .clock_i(clk), .reset_i(rst_n),
        .allocValid_i(alloc_v), .allocCount_i(alloc_c), .allocReady_o(alloc_rdy),
        .comp1Valid_i(c1_v), .comp1Index_i(c1_i),
        .comp2Valid_i(c2_v), .comp2Index_i(c2_i),
        .flush_i(flush),
        .rdAddr1_o(rda[0]), .rdAddr2_o(rda[1]), .rdAddr3_o(rda[2]), .rdAddr4_o(rda[3]),
        .rdData1_i(rdd[0]), .rdData2_i(rdd[1]), .rdData3_i(rdd[2]), .rdData4_i(rdd[3]),
        .retire1Valid_o(rv[0]), .retire2Valid_o(rv[1]),
        .retire3Valid_o(rv[2]), .retire4Valid_o(rv[3]),
        .retire1Index_o(ridx[0]), .retire2Index_o(ridx[1]),
        .retire3Index_o(ridx[2]), .retire4Index_o(ridx[3]),
        .retire1RegId_o(rreg[0]), .retire2RegId_o(rreg[1]),
        .retire3RegId_o(rreg[2]), .retire4RegId_o(rreg[3]),
        .head_o(head), .occupancy_o(occ),
        .isEmpty_o(empty), .isFull_o(full), .compErr_o(err)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_done[i] = 1'b0;
        m_head = 0;
        m_occ  = 0;
        m_err  = 1'b0;
        for (int n = 0; n < 4; n++) begin
            e_v[n] = 1'b0; e_idx[n] = 0; e_reg[n] = 0;
        end
    endtask

    // One clock of ROB behaviour, evaluated on the pre-edge state.
    task automatic model_step(input bit av, input int ac, input bit v1, input int i1,
                              input bit v2, input int i2, input bit fl);
        int k;
        int old_head, old_occ, tail;
        k = 0;
        while (k < 4 && k < m_occ && m_done[(m_head + k) % N]) k++;
        old_head = m_head;
        old_occ  = m_occ;
        if (fl) begin
            for (int n = 0; n < 4; n++) e_v[n] = 1'b0;
            for (int i = 0; i < N; i++) m_done[i] = 1'b0;
            m_head = (m_head + m_occ) % N;
            m_occ  = 0;
            return;
        end
        for (int n = 0; n < 4; n++) begin
            e_v[n]   = (n < k);
            e_idx[n] = (old_head + n) % N;
            e_reg[n] = dest_mem[e_idx[n]];
        end
        if (v1) begin
            if (((i1 - old_head + N) % N) < old_occ) m_done[i1] = 1'b1; else m_err = 1'b1;
        end
        if (v2) begin
            if (((i2 - old_head + N) % N) < old_occ) m_done[i2] = 1'b1; else m_err = 1'b1;
        end
        for (int n = 0; n < k; n++) m_done[(old_head + n) % N] = 1'b0;
        if (av && old_occ <= N - 4 && ac >= 1 && ac <= 4) begin
            tail = (old_head + old_occ) % N;
            for (int n = 0; n < ac; n++) m_done[(tail + n) % N] = 1'b0;
            m_occ = m_occ + ac;
        end
        m_occ  = m_occ - k;
        m_head = (m_head + k) % N;
    endtask

    task automatic check_state();
        for (int n = 0; n < 4; n++) begin
            check_eq($sformatf("ret%0d_valid", n + 1), int'(rv[n]), int'(e_v[n]));
            if (e_v[n]) begin
                check_eq($sformatf("ret%0d_index", n + 1), int'(ridx[n]), e_idx[n]);
                check_eq($sformatf("ret%0d_regid", n + 1), int'(rreg[n]), e_reg[n]);
            end
        end
        check_eq("head", int'(head), m_head);
        check_eq("occupancy", int'(occ), m_occ);
        check_eq("is_empty", int'(empty), int'(m_occ == 0));
        check_eq("is_full", int'(full), int'(m_occ == N));
        check_eq("alloc_ready", int'(alloc_rdy), int'(m_occ <= N - 4));
        check_eq("comp_err", int'(err), int'(m_err));
    endtask

    task automatic step(input bit av, input int ac, input bit v1, input int i1,
                        input bit v2, input int i2, input bit fl);
        @(negedge clk);
        alloc_v = av; alloc_c = 3'(ac);
        c1_v = v1; c1_i = 7'(i1);
        c2_v = v2; c2_i = 7'(i2);
        flush = fl;
        model_step(av, ac, v1, i1, v2, i2, fl);
        @(posedge clk);
        #1;
        check_state();
        $display("step alloc=%0d/%0d c1=%0d/%0d c2=%0d/%0d flush=%0d -> head=%0d occ=%0d rv=%b",
                 av, ac, v1, i1, v2, i2, fl, head, occ, rv);
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset is asserted off the clock edge so only an asynchronous clear can satisfy the checks.
    task automatic do_reset();
        alloc_v = 1'b0; c1_v = 1'b0; c2_v = 1'b0; flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        for (int n = 0; n < 4; n++) begin
            check_eq("rst_index", int'(ridx[n]), 0);
            check_eq("rst_regid", int'(rreg[n]), 0);
        end
        $display("reset asserted -> head=%0d occ=%0d empty=%0d ready=%0d", head, occ, empty, alloc_rdy);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) dest_mem[i] = 5'($urandom);
        model_reset();
        do_reset();

        // Out-of-order completion, single 4-wide retire.
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Gap at head blocks retirement.
        do_reset();
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 2, 0);
        idle(10);
        step(0, 0, 1, 0, 0, 0, 0);
        idle(2);

        // Fill to full, then hold allocation while full.
        do_reset();
        for (int c = 0; c < 32; c++) step(1, 4, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // Walk head to 126, then retire across the wrap.
        do_reset();
        for (int c = 0; c < 31; c++) begin
            step(1, 4, 0, 0, 0, 0, 0);
            step(0, 0, 1, (4 * c) % N, 1, (4 * c + 1) % N, 0);
            step(0, 0, 1, (4 * c + 2) % N, 1, (4 * c + 3) % N, 0);
            idle(1);
        end
        step(1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 1, 124, 1, 125, 0);
        idle(1);
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 127, 1, 0, 0);
        step(0, 0, 1, 1, 1, 126, 0);
        idle(2);

        // Completion outside the in-flight window is flagged and sticky.
        do_reset();
        step(1, 4, 0, 0, 0, 0, 0);
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 50, 0, 0, 0);
        idle(3);

        // Flush with simultaneous alloc and completion.
        do_reset();
        step(1, 4, 0, 0, 0, 0, 0);
        step(1, 4, 1, 1, 1, 2, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        step(1, 4, 1, 0, 0, 0, 1);
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 1, 8, 1, 9, 0);
        idle(2);

        // Reset while retire outputs are active.
        do_reset();
        step(1, 4, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1, 1, 0);
        step(0, 0, 1, 2, 1, 3, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            bit av, v1, v2, fl;
            int ac, i1, i2;
            if (c % 1000 == 999) do_reset();
            av = ($urandom_range(0, 2) != 0);
            ac = $urandom_range(1, 4);
            v1 = ($urandom_range(0, 3) != 0);
            v2 = ($urandom_range(0, 2) != 0);
            i1 = (m_occ > 0 && $urandom_range(0, 15) != 0) ?
                 (m_head + $urandom_range(0, m_occ - 1)) % N : $urandom_range(0, N - 1);
            i2 = (m_occ > 0 && $urandom_range(0, 15) != 0) ?
                 (m_head + $urandom_range(0, m_occ - 1)) % N : $urandom_range(0, N - 1);
            fl = ($urandom_range(0, 63) == 0);
            step(av, ac, v1, i1, v2, i2, fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
